// File: rtl/tcp_tx_session_arbiter.sv
// Round-robin arbiter sharing one TCP TX metadata/status/data path among NUM_REQ requesters.
// Each packet: issue metadata, await status, then forward the burst (ok) or drain it (error/timeout).
module tcp_tx_session_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned STATUS_TIMEOUT = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_REQ-1:0]       s_req_meta_TVALID,
  output logic [NUM_REQ-1:0]       s_req_meta_TREADY,
  input  logic [32*NUM_REQ-1:0]    s_req_meta_TDATA,
  input  logic [NUM_REQ-1:0]       s_req_data_TVALID,
  output logic [NUM_REQ-1:0]       s_req_data_TREADY,
  input  logic [512*NUM_REQ-1:0]   s_req_data_TDATA,
  input  logic [64*NUM_REQ-1:0]    s_req_data_TKEEP,
  input  logic [NUM_REQ-1:0]       s_req_data_TLAST,
  output logic                     m_axis_tx_metadata_TVALID,
  input  logic                     m_axis_tx_metadata_TREADY,
  output logic [31:0]              m_axis_tx_metadata_TDATA,
  input  logic                     s_axis_tx_status_TVALID,
  output logic                     s_axis_tx_status_TREADY,
  input  logic [63:0]              s_axis_tx_status_TDATA,
  output logic                     m_axis_tx_data_TVALID,
  input  logic                     m_axis_tx_data_TREADY,
  output logic [511:0]             m_axis_tx_data_TDATA,
  output logic [63:0]              m_axis_tx_data_TKEEP,
  output logic                     m_axis_tx_data_TLAST,
  output logic [1:0]               grant_id,
  output logic                     busy,
  output logic [15:0]              drop_count
);

  localparam int unsigned TimerW = $clog2(STATUS_TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(STATUS_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSendMeta, StWaitStatus, StStream, StDrain} state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [31:0]         meta_q, meta_d;
  logic [15:0]         drop_q, drop_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [31:0]         pick_meta;
  int unsigned         scan_idx;

  logic [NUM_REQ-1:0]  grant_oh;
  logic                sel_valid;
  logic                sel_last;
  logic [511:0]        sel_data;
  logic [63:0]         sel_keep;

  logic [NUM_REQ-1:0]  meta_ready;
  logic [NUM_REQ-1:0]  data_ready;
  logic                tx_valid;
  logic                status_ready;
  logic [15:0]         drop_inc;

  logic                unused_status;
  assign unused_status = ^s_axis_tx_status_TDATA[61:0];

  // Scan starts one past the last served requester so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_meta  = '0;
    scan_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && (scan_idx == i) && s_req_meta_TVALID[i]) begin
          pick_found = 1'b1;
          pick_idx   = 2'(i);
          pick_oh[i] = 1'b1;
          pick_meta  = s_req_meta_TDATA[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        grant_oh[i] = 1'b1;
        sel_valid   = s_req_data_TVALID[i];
        sel_last    = s_req_data_TLAST[i];
        sel_data    = s_req_data_TDATA[512*i +: 512];
        sel_keep    = s_req_data_TKEEP[64*i +: 64];
      end
    end
  end

  assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    meta_d       = meta_q;
    drop_d       = drop_q;
    timer_d      = timer_q;
    meta_ready   = '0;
    data_ready   = '0;
    tx_valid     = 1'b0;
    status_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          meta_d     = pick_meta;
          meta_ready = pick_oh;
          state_d    = StSendMeta;
        end
      end
      StSendMeta: begin
        if (m_axis_tx_metadata_TREADY) begin
          timer_d = '0;
          state_d = StWaitStatus;
        end
      end
      StWaitStatus: begin
        status_ready = 1'b1;
        // A status beat wins over a timeout landing in the same cycle.
        if (s_axis_tx_status_TVALID) begin
          if (s_axis_tx_status_TDATA[63:62] == 2'b00) begin
            state_d = StStream;
          end else begin
            drop_d  = drop_inc;
            state_d = StDrain;
          end
        end else if (timer_q == TimerLast) begin
          drop_d  = drop_inc;
          state_d = StDrain;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StStream: begin
        tx_valid   = sel_valid;
        data_ready = grant_oh & {NUM_REQ{m_axis_tx_data_TREADY}};
        if (sel_valid && sel_last && m_axis_tx_data_TREADY) begin
          ptr_d   = grant_q;
          state_d = StIdle;
        end
      end
      StDrain: begin
        data_ready = grant_oh;
        if (sel_valid && sel_last) begin
          ptr_d   = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      meta_q  <= '0;
      drop_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      meta_q  <= meta_d;
      drop_q  <= drop_d;
      timer_q <= timer_d;
    end
  end

  // The IDLE-cycle pick is combinational on requester valids; hold it off while in reset.
  assign s_req_meta_TREADY         = meta_ready & {NUM_REQ{aresetn}};
  assign s_req_data_TREADY         = data_ready;
  assign m_axis_tx_metadata_TVALID = (state_q == StSendMeta);
  assign m_axis_tx_metadata_TDATA  = meta_q;
  assign s_axis_tx_status_TREADY   = status_ready;
  assign m_axis_tx_data_TVALID     = tx_valid;
  assign m_axis_tx_data_TDATA      = sel_data;
  assign m_axis_tx_data_TKEEP      = sel_keep;
  assign m_axis_tx_data_TLAST      = sel_last;
  assign grant_id                  = grant_q;
  assign busy                      = (state_q != StIdle);
  assign drop_count                = drop_q;

endmodule

// File: tb/tb_tcp_tx_session_arbiter.sv
// Scoreboard bench for tcp_tx_session_arbiter: requester/stack models driven on the falling
// edge, handshakes resolved and compared shortly after, ahead of the rising edge.
module tb_tcp_tx_session_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     s_req_meta_TVALID;
  logic [NR-1:0]     s_req_meta_TREADY;
  logic [32*NR-1:0]  s_req_meta_TDATA;
  logic [NR-1:0]     s_req_data_TVALID;
  logic [NR-1:0]     s_req_data_TREADY;
  logic [512*NR-1:0] s_req_data_TDATA;
  logic [64*NR-1:0]  s_req_data_TKEEP;
  logic [NR-1:0]     s_req_data_TLAST;
  logic              m_axis_tx_metadata_TVALID;
  logic              m_axis_tx_metadata_TREADY;
  logic [31:0]       m_axis_tx_metadata_TDATA;
  logic              s_axis_tx_status_TVALID;
  logic              s_axis_tx_status_TREADY;
  logic [63:0]       s_axis_tx_status_TDATA;
  logic              m_axis_tx_data_TVALID;
  logic              m_axis_tx_data_TREADY;
  logic [511:0]      m_axis_tx_data_TDATA;
  logic [63:0]       m_axis_tx_data_TKEEP;
  logic              m_axis_tx_data_TLAST;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       drop_count;

  tcp_tx_session_arbiter #(
    .NUM_REQ        (NR),
    .STATUS_TIMEOUT (TO)
  ) dut (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .s_req_meta_TVALID         (s_req_meta_TVALID),
    .s_req_meta_TREADY         (s_req_meta_TREADY),
    .s_req_meta_TDATA          (s_req_meta_TDATA),
    .s_req_data_TVALID         (s_req_data_TVALID),
    .s_req_data_TREADY         (s_req_data_TREADY),
    .s_req_data_TDATA          (s_req_data_TDATA),
    .s_req_data_TKEEP          (s_req_data_TKEEP),
    .s_req_data_TLAST          (s_req_data_TLAST),
    .m_axis_tx_metadata_TVALID (m_axis_tx_metadata_TVALID),
    .m_axis_tx_metadata_TREADY (m_axis_tx_metadata_TREADY),
    .m_axis_tx_metadata_TDATA  (m_axis_tx_metadata_TDATA),
    .s_axis_tx_status_TVALID   (s_axis_tx_status_TVALID),
    .s_axis_tx_status_TREADY   (s_axis_tx_status_TREADY),
    .s_axis_tx_status_TDATA    (s_axis_tx_status_TDATA),
    .m_axis_tx_data_TVALID     (m_axis_tx_data_TVALID),
    .m_axis_tx_data_TREADY     (m_axis_tx_data_TREADY),
    .m_axis_tx_data_TDATA      (m_axis_tx_data_TDATA),
    .m_axis_tx_data_TKEEP      (m_axis_tx_data_TKEEP),
    .m_axis_tx_data_TLAST      (m_axis_tx_data_TLAST),
    .grant_id                  (grant_id),
    .busy                      (busy),
    .drop_count                (drop_count)
  );

  always #5 aclk = ~aclk;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  logic [31:0] meta_fifo [NR][$];
  beat_t       beat_fifo [NR][$];
  beat_t       exp_beats [$];
  logic [33:0] exp_meta  [$];
  logic [63:0] status_fifo [$];

  bit [NR-1:0] data_en = '1;
  bit          late_status = 1'b0;
  bit          tx_toggle = 1'b0;
  bit          tx_phase = 1'b1;
  int unsigned meta_stall_left = 0;
  int unsigned meta_stall_seen = 0;
  int unsigned status_rdy_cnt = 0;
  bit          meta_was_stalled = 1'b0;
  logic [31:0] meta_prev = '0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int unsigned r, input logic [31:0] meta, input int unsigned nbeats,
                         input bit fwd, input logic [1:0] gnt, input bit has_st,
                         input logic [63:0] st);
    beat_t b;
    meta_fifo[r].push_back(meta);
    exp_meta.push_back({gnt, meta});
    if (has_st) status_fifo.push_back(st);
    for (int unsigned k = 0; k < nbeats; k++) begin
      b.data = {16{$urandom()}} ^ 512'(k);
      b.keep = {$urandom(), $urandom()};
      b.last = (k == nbeats - 1);
      beat_fifo[r].push_back(b);
      if (fwd) exp_beats.push_back(b);
    end
  endtask

  function automatic bit all_empty();
    bit e = (exp_beats.size() == 0) && (exp_meta.size() == 0) && (status_fifo.size() == 0);
    for (int i = 0; i < NR; i++) e = e && (meta_fifo[i].size() == 0) && (beat_fifo[i].size() == 0);
    return e;
  endfunction

  task automatic step();
    beat_t       e;
    logic [33:0] em;
    logic        rdy_g;
    @(negedge aclk);
    for (int i = 0; i < NR; i++) begin
      s_req_meta_TVALID[i]          = (meta_fifo[i].size() != 0);
      s_req_meta_TDATA[32*i +: 32]  = (meta_fifo[i].size() != 0) ? meta_fifo[i][0] : 32'h0;
      s_req_data_TVALID[i]          = (beat_fifo[i].size() != 0) && data_en[i];
      s_req_data_TDATA[512*i +: 512] = (beat_fifo[i].size() != 0) ? beat_fifo[i][0].data : '0;
      s_req_data_TKEEP[64*i +: 64]  = (beat_fifo[i].size() != 0) ? beat_fifo[i][0].keep : '0;
      s_req_data_TLAST[i]           = (beat_fifo[i].size() != 0) ? beat_fifo[i][0].last : 1'b0;
    end
    m_axis_tx_metadata_TREADY = (meta_stall_left == 0);
    m_axis_tx_data_TREADY     = tx_toggle ? tx_phase : 1'b1;
    tx_phase                  = ~tx_phase;
    s_axis_tx_status_TVALID   = late_status || (status_fifo.size() != 0);
    s_axis_tx_status_TDATA    = (!late_status && status_fifo.size() != 0) ? status_fifo[0] : 64'h0;
    #2;
    if (meta_was_stalled) begin
      check_eq("meta_hold_valid", m_axis_tx_metadata_TVALID, 1'b1);
      check_eq("meta_hold_data", m_axis_tx_metadata_TDATA, meta_prev);
    end
    meta_was_stalled = m_axis_tx_metadata_TVALID && !m_axis_tx_metadata_TREADY;
    meta_prev        = m_axis_tx_metadata_TDATA;
    if (meta_was_stalled) begin
      meta_stall_left--;
      meta_stall_seen++;
    end
    if (m_axis_tx_metadata_TVALID && m_axis_tx_metadata_TREADY) begin
      if (exp_meta.size() == 0) check_eq("meta_unexpected", 1'b1, 1'b0);
      else begin
        em = exp_meta.pop_front();
        check_eq("meta_data", m_axis_tx_metadata_TDATA, em[31:0]);
        check_eq("meta_grant", grant_id, em[33:32]);
      end
    end
    if (s_axis_tx_status_TREADY) status_rdy_cnt++;
    if (late_status) check_eq("late_status_ready", s_axis_tx_status_TREADY, 1'b0);
    else if (s_axis_tx_status_TVALID && s_axis_tx_status_TREADY) void'(status_fifo.pop_front());
    if (m_axis_tx_data_TVALID) begin
      rdy_g = |(s_req_data_TREADY & (NR'(1) << grant_id));
      check_eq("backpressure_mirror", rdy_g, m_axis_tx_data_TREADY);
      if (m_axis_tx_data_TREADY) begin
        if (exp_beats.size() == 0) check_eq("beat_unexpected", 1'b1, 1'b0);
        else begin
          e = exp_beats.pop_front();
          check_eq("beat_data", m_axis_tx_data_TDATA, e.data);
          check_eq("beat_keep_last", {m_axis_tx_data_TKEEP, m_axis_tx_data_TLAST}, {e.keep, e.last});
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (s_req_meta_TVALID[i] && s_req_meta_TREADY[i]) void'(meta_fifo[i].pop_front());
      if (s_req_data_TVALID[i] && s_req_data_TREADY[i]) void'(beat_fifo[i].pop_front());
    end
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned n = 0;
    bit done = 1'b0;
    while (!done && n < limit) begin
      step();
      n++;
      done = !busy && all_empty();
    end
    check_eq(tag, done, 1'b1);
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) begin
      meta_fifo[i].delete();
      beat_fifo[i].delete();
    end
    exp_beats.delete();
    exp_meta.delete();
    status_fifo.delete();
  endtask

  initial begin
    int unsigned n;
    aresetn                   = 1'b0;
    s_req_meta_TVALID         = '0;
    s_req_meta_TDATA          = '0;
    s_req_data_TVALID         = '0;
    s_req_data_TDATA          = '0;
    s_req_data_TKEEP          = '0;
    s_req_data_TLAST          = '0;
    m_axis_tx_metadata_TREADY = 1'b0;
    s_axis_tx_status_TVALID   = 1'b0;
    s_axis_tx_status_TDATA    = '0;
    m_axis_tx_data_TREADY     = 1'b0;
    #1;
    check_eq("rst_handshakes", {m_axis_tx_metadata_TVALID, m_axis_tx_data_TVALID,
             s_axis_tx_status_TREADY, s_req_meta_TREADY, s_req_data_TREADY}, '0);
    check_eq("rst_regs", {m_axis_tx_metadata_TDATA, grant_id, drop_count, busy}, '0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Single packet, OK status, two beats.
    add_pkt(0, 32'h0040_0005, 2, 1'b1, 2'd0, 1'b1, 64'h0);
    wait_done("t1_done", 50);
    check_eq("t1_grant", grant_id, 2'd0);

    // Both requesters loaded: grants alternate starting at 1.
    add_pkt(1, 32'h0020_0101, 2, 1'b1, 2'd1, 1'b1, 64'h0);
    add_pkt(0, 32'h0030_0002, 3, 1'b1, 2'd0, 1'b1, 64'h0);
    add_pkt(1, 32'h0010_0103, 1, 1'b1, 2'd1, 1'b1, 64'h0);
    add_pkt(0, 32'h0020_0004, 2, 1'b1, 2'd0, 1'b1, 64'h0);
    wait_done("t2_done", 200);
    check_eq("t2_drop", drop_count, 16'd0);

    // Rejected packet drained, then a normal single-beat packet.
    add_pkt(1, 32'h0060_0110, 3, 1'b0, 2'd1, 1'b1, 64'h4000_0000_0000_0000);
    add_pkt(0, 32'h0040_0011, 1, 1'b1, 2'd0, 1'b1, 64'h0);
    wait_done("t3_done", 100);
    check_eq("t3_drop", drop_count, 16'd1);

    // Status never arrives: timeout after TO cycles in WAIT_STATUS.
    data_en[1]     = 1'b0;
    status_rdy_cnt = 0;
    add_pkt(1, 32'h0040_0120, 2, 1'b0, 2'd1, 1'b0, 64'h0);
    n = 0;
    while (n < 200 && !(status_rdy_cnt > 0 && !s_axis_tx_status_TREADY)) begin
      step();
      n++;
    end
    check_eq("t4_wait_cycles", status_rdy_cnt, TO);
    check_eq("t4_drop", drop_count, 16'd2);
    check_eq("t4_busy", busy, 1'b1);
    late_status = 1'b1;
    repeat (3) step();
    late_status = 1'b0;
    data_en[1]  = 1'b1;
    wait_done("t4_done", 50);

    // Metadata stalled 5 cycles, data TREADY toggling over a 4-beat burst.
    meta_stall_left = 5;
    meta_stall_seen = 0;
    tx_toggle       = 1'b1;
    add_pkt(0, 32'h0100_0030, 4, 1'b1, 2'd0, 1'b1, 64'h0);
    wait_done("t5_done", 100);
    tx_toggle = 1'b0;
    check_eq("t5_stall_cycles", meta_stall_seen, 5);

    // Reset asserted after the first of three beats.
    add_pkt(1, 32'h0060_0140, 3, 1'b1, 2'd1, 1'b1, 64'h0);
    n = 0;
    while (n < 100 && exp_beats.size() != 2) begin
      step();
      n++;
    end
    check_eq("t6_first_beat", exp_beats.size(), 2);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("t6_rst_handshakes", {m_axis_tx_metadata_TVALID, m_axis_tx_data_TVALID,
             s_axis_tx_status_TREADY, s_req_meta_TREADY, s_req_data_TREADY}, '0);
    check_eq("t6_rst_regs", {m_axis_tx_metadata_TDATA, grant_id, drop_count, busy}, '0);
    flush();
    s_req_meta_TVALID = '0;
    s_req_data_TVALID = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    step();
    check_eq("t6_idle_after", {busy, drop_count}, '0);
    add_pkt(0, 32'h0040_0150, 1, 1'b1, 2'd0, 1'b1, 64'h0);
    wait_done("t6_recover", 50);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
